// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants and the shadow-pipeline entry type used by the
// forwarding / hazard logic.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       load;
  } pipe_entry_t;

  // True when entry e will produce the value of architectural register src.
  function automatic logic entry_writes(input pipe_entry_t e, input logic [4:0] src);
    return e.valid && e.wr && (e.rd == src) && (src != 5'd0);
  endfunction

endpackage

// File: rtl/instr_regs_decode.sv
// Register-usage classification of an RV32I instruction: which sources are
// read, whether rd is written, and whether the result comes from a load.
module instr_regs_decode
  import riscv_pkg::*;
(
  input  logic [31:0] id_instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        wr,
  output logic        load
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = id_instr[6:0];
  assign rd          = id_instr[11:7];
  assign rs1         = id_instr[19:15];
  assign rs2         = id_instr[24:20];
  assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr      = 1'b0;
    load    = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr      = 1'b1;
      end
      OPC_OP_IMM, OPC_JALR: begin
        use_rs1 = 1'b1;
        wr      = 1'b1;
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1;
        wr      = 1'b1;
        load    = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: begin
        wr = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use / interlock stall generation against a
// shadow copy of the downstream pipeline (stage 1 = EX ... stage DEPTH = WB).
module fwd_hazard_unit
  import riscv_pkg::*;
#(
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  parameter  int FWD_EN   = 1,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic            pipe_hold,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] fwd_sel_rs1,
  output logic [SELW-1:0] fwd_sel_rs2,
  output logic [15:0]     stall_count
);

  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_use_rs1, dec_use_rs2, dec_wr, dec_load;

  instr_regs_decode u_decode (
    .id_instr (id_instr),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .use_rs1  (dec_use_rs1),
    .use_rs2  (dec_use_rs2),
    .wr       (dec_wr),
    .load     (dec_load)
  );

  pipe_entry_t stage_q [1:DEPTH];
  pipe_entry_t stage_d [1:DEPTH];
  pipe_entry_t new_entry;
  logic [15:0] count_q, count_d;

  logic            hit1, hit2, blk1, blk2, active, stall_raw;
  logic [SELW-1:0] age1, age2;

  // Scan oldest to youngest so the youngest matching stage overwrites.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    blk1 = 1'b0;
    blk2 = 1'b0;
    age1 = '0;
    age2 = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (dec_use_rs1 && entry_writes(stage_q[k], dec_rs1)) begin
        hit1 = 1'b1;
        age1 = SELW'(k);
        blk1 = stage_q[k].load && (k <= LOAD_LAT);
      end
      if (dec_use_rs2 && entry_writes(stage_q[k], dec_rs2)) begin
        hit2 = 1'b1;
        age2 = SELW'(k);
        blk2 = stage_q[k].load && (k <= LOAD_LAT);
      end
    end
  end

  assign active    = id_valid && !flush;
  assign stall_raw = (FWD_EN != 0) ? ((hit1 && blk1) || (hit2 && blk2)) : (hit1 || hit2);
  assign stall     = active && stall_raw;

  assign fwd_sel_rs1 = (active && (FWD_EN != 0)) ? age1 : '0;
  assign fwd_sel_rs2 = (active && (FWD_EN != 0)) ? age2 : '0;

  // A destination of x0 never produces a forwardable value.
  always_comb begin
    new_entry = '0;
    if (id_valid && !stall && !flush) begin
      new_entry.valid = 1'b1;
      new_entry.rd    = dec_rd;
      new_entry.wr    = dec_wr && (dec_rd != 5'd0);
      new_entry.load  = dec_load;
    end
  end

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    count_d = count_q;
    if (!pipe_hold) begin
      stage_d[1] = new_entry;
      for (int k = 2; k <= DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (stall && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      count_q <= count_d;
    end
  end

  assign stall_count = count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: three configurations (default, interlock-only, deep with
// two-cycle load latency) driven in parallel against a slot-history model.
module tb_fwd_hazard_unit;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, pipe_hold, flush;
  logic [31:0] id_instr;

  logic        st_a, st_b, st_c;
  logic [1:0]  s1_a, s2_a, s1_b, s2_b;
  logic [2:0]  s1_c, s2_c;
  logic [15:0] c_a, c_b, c_c;

  always #5 clk = ~clk;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .pipe_hold(pipe_hold), .flush(flush), .stall(st_a),
    .fwd_sel_rs1(s1_a), .fwd_sel_rs2(s2_a), .stall_count(c_a)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(1), .FWD_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .pipe_hold(pipe_hold), .flush(flush), .stall(st_b),
    .fwd_sel_rs1(s1_b), .fwd_sel_rs2(s2_b), .stall_count(c_b)
  );

  fwd_hazard_unit #(.DEPTH(4), .LOAD_LAT(2), .FWD_EN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .pipe_hold(pipe_hold), .flush(flush), .stall(st_c),
    .fwd_sel_rs1(s1_c), .fwd_sel_rs2(s2_c), .stall_count(c_c)
  );

  function automatic int p_depth(input int i);
    return (i == 2) ? 4 : 3;
  endfunction
  function automatic int p_lat(input int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic bit p_fwd(input int i);
    return (i != 1);
  endfunction

  // One issued slot per non-held cycle; wrd = 0 means "writes nothing useful".
  typedef struct {
    bit v;
    int wrd;
    bit ld;
  } slot_t;

  typedef struct {
    int inst;
    bit st;
    bit chk_sel;
    int s1;
    int s2;
    int cnt;
  } exp_t;

  slot_t hist [NI*5];
  int    cnt_m [NI];
  exp_t  sb [$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic void classify(input logic [31:0] ins, output bit u1, output bit u2,
                                   output int wrd, output bit ld);
    logic [6:0] op;
    bit w;
    op = ins[6:0];
    u1 = 0; u2 = 0; w = 0; ld = 0;
    case (op)
      7'h33:               begin u1 = 1; u2 = 1; w = 1; end
      7'h13, 7'h67:        begin u1 = 1; w = 1; end
      7'h03:               begin u1 = 1; w = 1; ld = 1; end
      7'h23, 7'h63:        begin u1 = 1; u2 = 1; end
      7'h6F, 7'h37, 7'h17: w = 1;
      default:             w = 0;
    endcase
    wrd = w ? int'(ins[11:7]) : 0;
  endfunction

  function automatic int youngest(input int i, input int src);
    for (int a = 1; a <= p_depth(i); a++)
      if (hist[i*5+a].v && hist[i*5+a].wrd == src) return a;
    return 0;
  endfunction

  task automatic check(input string name, input int inst, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", name, inst, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, predict every configuration, advance the model.
  task automatic step(input bit rst, input bit v, input logic [31:0] ins,
                      input bit hold, input bit fl);
    bit   u1, u2, ld, act, st;
    int   wrd, r1, r2, a1, a2;
    exp_t e;
    rst_n = rst; id_valid = v; id_instr = ins; pipe_hold = hold; flush = fl;
    classify(ins, u1, u2, wrd, ld);
    r1 = int'(ins[19:15]);
    r2 = int'(ins[24:20]);
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        for (int a = 0; a < 5; a++) hist[i*5+a] = '{0, 0, 0};
        cnt_m[i] = 0;
      end
      act = rst && v && !fl;
      a1 = (u1 && r1 != 0) ? youngest(i, r1) : 0;
      a2 = (u2 && r2 != 0) ? youngest(i, r2) : 0;
      if (p_fwd(i))
        st = act && ((a1 != 0 && hist[i*5+a1].ld && a1 <= p_lat(i)) ||
                     (a2 != 0 && hist[i*5+a2].ld && a2 <= p_lat(i)));
      else
        st = act && (a1 != 0 || a2 != 0);
      e.inst = i; e.st = st; e.chk_sel = !st; e.cnt = cnt_m[i];
      e.s1 = (act && p_fwd(i)) ? a1 : 0;
      e.s2 = (act && p_fwd(i)) ? a2 : 0;
      sb.push_back(e);
      if (rst && !hold) begin
        for (int a = p_depth(i); a >= 2; a--) hist[i*5+a] = hist[i*5+a-1];
        if (act && !st) hist[i*5+1] = '{1, wrd, ld};
        else            hist[i*5+1] = '{0, 0, 0};
        if (st && cnt_m[i] < 65535) cnt_m[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int ast, as1, as2, acnt;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0:       begin ast = int'(st_a); as1 = int'(s1_a); as2 = int'(s2_a); acnt = int'(c_a); end
        1:       begin ast = int'(st_b); as1 = int'(s1_b); as2 = int'(s2_b); acnt = int'(c_b); end
        default: begin ast = int'(st_c); as1 = int'(s1_c); as2 = int'(s2_c); acnt = int'(c_c); end
      endcase
      check("stall", e.inst, ast, int'(e.st));
      check("stall_count", e.inst, acnt, e.cnt);
      if (e.chk_sel) begin
        check("fwd_sel_rs1", e.inst, as1, e.s1);
        check("fwd_sel_rs2", e.inst, as2, e.s2);
      end
    end
  end

  localparam logic [31:0] ADDI_X1  = 32'h00100093;
  localparam logic [31:0] ADD_X2   = 32'h00108133;
  localparam logic [31:0] LW_X3    = 32'h0000A183;
  localparam logic [31:0] ADD_X4   = 32'h00318233;
  localparam logic [31:0] ADDI_X0  = 32'h00008013;
  localparam logic [31:0] NOP      = 32'h00000013;

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h73};
    ins = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 9)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; pipe_hold = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, NOP, 0, 0);
    step(0, 1, ADD_X4, 0, 0);

    // Plain ALU dependency: forward from stage 1 (interlock config stalls 3 cycles).
    step(1, 1, ADDI_X1, 0, 0);
    repeat (4) step(1, 1, ADD_X2, 0, 0);
    repeat (4) step(1, 0, NOP, 0, 0);

    // Load-use: one stall cycle, then forward from stage 2.
    step(1, 1, LW_X3, 0, 0);
    repeat (3) step(1, 1, ADD_X4, 0, 0);
    repeat (4) step(1, 0, NOP, 0, 0);

    // Writes to x0 never match.
    step(1, 1, ADDI_X0, 0, 0);
    step(1, 1, NOP, 0, 0);
    repeat (4) step(1, 0, NOP, 0, 0);

    // Flush beats stall; hold freezes the pipeline and the counter.
    step(1, 1, LW_X3, 0, 0);
    step(1, 1, ADD_X4, 0, 1);
    step(1, 1, ADD_X4, 0, 0);
    repeat (2) step(1, 1, ADD_X4, 1, 0);
    repeat (3) step(1, 1, ADD_X4, 0, 0);
    repeat (4) step(1, 0, NOP, 0, 0);

    // Reset in the middle of a load-use stall.
    step(1, 1, LW_X3, 0, 0);
    step(1, 1, ADD_X4, 0, 0);
    step(0, 1, ADD_X4, 0, 0);
    repeat (2) step(1, 1, ADD_X4, 0, 0);

    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 7) != 0), rand_instr(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    repeat (4) step(1, 0, NOP, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
